// File: rtl/mem_bist_pkg.sv
// Shared definitions for the memory BIST initiator.
//   - state_e    : run sequencer states
//   - ERR_CNT_W  : width of the saturating mismatch counter
//   - lfsr_next  : one Galois LFSR step, evaluated at LFSR_MAX_W bits
package mem_bist_pkg;

    localparam int unsigned ERR_CNT_W  = 8;
    localparam int unsigned LFSR_MAX_W = 32;

    typedef enum logic [2:0] {
        StIdle,
        StWrite,
        StRead,
        StWait,
        StDone
    } state_e;

    // Callers zero-extend narrower states and masks; the shifted-in zero
    // keeps the upper bits clear, so truncating the result is exact.
    function automatic logic [LFSR_MAX_W-1:0] lfsr_next(
        input logic [LFSR_MAX_W-1:0] s,
        input logic [LFSR_MAX_W-1:0] taps
    );
        return s[0] ? ((s >> 1) ^ taps) : (s >> 1);
    endfunction

endpackage

// File: rtl/mem_bist_if.sv
// Single-port memory bus between the BIST initiator and the memory.
//   addr   : memory address            (master -> slave)
//   wr_en  : write strobe              (master -> slave)
//   rd_en  : read strobe               (master -> slave)
//   wdata  : write data                (master -> slave)
//   rdata  : read data, valid a fixed number of clocks after rd_en (slave -> master)
interface mem_bist_if #(
    parameter int unsigned ADDR_WIDTH = 2,
    parameter int unsigned DATA_WIDTH = 8
) ();

    logic [ADDR_WIDTH-1:0] addr;
    logic                  wr_en;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] wdata;
    logic [DATA_WIDTH-1:0] rdata;

    modport master (
        output addr,
        output wr_en,
        output rd_en,
        output wdata,
        input  rdata
    );

    modport slave (
        input  addr,
        input  wr_en,
        input  rd_en,
        input  wdata,
        output rdata
    );

endinterface

// File: rtl/mem_bist_lfsr.sv
// Galois LFSR pattern source for the BIST initiator.
//   i_clk     : clock
//   i_reset   : synchronous active-low reset, state returns to 1
//   i_load    : load i_seed (takes priority over i_advance)
//   i_seed    : load value, expected non-zero
//   i_advance : step the LFSR once
//   o_state   : current LFSR state
module mem_bist_lfsr
    import mem_bist_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH = 8,
    parameter logic [DATA_WIDTH-1:0] LFSR_TAPS  = DATA_WIDTH'(8'hB8)
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_load,
    input  logic [DATA_WIDTH-1:0] i_seed,
    input  logic                  i_advance,
    output logic [DATA_WIDTH-1:0] o_state
);

    logic [DATA_WIDTH-1:0] r_state;
    logic [LFSR_MAX_W-1:0] w_next_full;
    logic                  w_unused_hi;

    assign w_next_full = lfsr_next(LFSR_MAX_W'(r_state), LFSR_MAX_W'(LFSR_TAPS));
    // Upper bits are always zero for zero-extended inputs.
    assign w_unused_hi = ^w_next_full[LFSR_MAX_W-1:DATA_WIDTH];

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state <= DATA_WIDTH'(1);
        end else if (i_load) begin
            r_state <= i_seed;
        end else if (i_advance) begin
            r_state <= w_next_full[DATA_WIDTH-1:0];
        end
    end

    assign o_state = r_state;

endmodule

// File: rtl/mem_bist_initiator.sv
// Memory BIST initiator: on start, issues NUM_TXN write/read-back pairs with
// LFSR data at consecutive (wrapping) addresses and compares each read.
//   i_clk, i_reset : clock, synchronous active-low reset
//   i_start        : begin a run (accepted only when idle)
//   i_abort        : end the run at the next edge, no done pulse
//   i_base_addr    : first address of the run
//   i_seed         : LFSR seed, 0 is replaced by 1
//   io_bus         : memory bus master (addr, wr_en, rd_en, wdata, rdata)
//   o_busy         : run in progress
//   o_done         : one-cycle pulse at normal completion
//   o_pass         : last completed run had no mismatches
//   o_err_cnt      : saturating mismatch count
//   o_fail_addr/o_fail_exp/o_fail_act : details of the first mismatch
// All outputs are registered.
module mem_bist_initiator
    import mem_bist_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH = 2,
    parameter int unsigned           DATA_WIDTH = 8,
    parameter int unsigned           NUM_TXN    = 5,
    parameter int unsigned           RD_LATENCY = 1,
    parameter logic [DATA_WIDTH-1:0] LFSR_TAPS  = DATA_WIDTH'(8'hB8)
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_start,
    input  logic                  i_abort,
    input  logic [ADDR_WIDTH-1:0] i_base_addr,
    input  logic [DATA_WIDTH-1:0] i_seed,
    mem_bist_if.master            io_bus,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_pass,
    output logic [ERR_CNT_W-1:0]  o_err_cnt,
    output logic [ADDR_WIDTH-1:0] o_fail_addr,
    output logic [DATA_WIDTH-1:0] o_fail_exp,
    output logic [DATA_WIDTH-1:0] o_fail_act
);

    localparam int unsigned LAT_W = $clog2(RD_LATENCY + 1);
    localparam int unsigned IDX_W = 8;

    state_e                r_state;
    state_e                w_state_d;

    logic [ADDR_WIDTH-1:0] r_addr,      w_addr_d;
    logic                  r_wr_en,     w_wr_en_d;
    logic                  r_rd_en,     w_rd_en_d;
    logic [DATA_WIDTH-1:0] r_wdata,     w_wdata_d;
    logic                  r_busy,      w_busy_d;
    logic                  r_done,      w_done_d;
    logic                  r_pass,      w_pass_d;
    logic [ERR_CNT_W-1:0]  r_err_cnt,   w_err_cnt_d;
    logic [ADDR_WIDTH-1:0] r_fail_addr, w_fail_addr_d;
    logic [DATA_WIDTH-1:0] r_fail_exp,  w_fail_exp_d;
    logic [DATA_WIDTH-1:0] r_fail_act,  w_fail_act_d;
    logic [IDX_W-1:0]      r_idx,       w_idx_d;
    logic [DATA_WIDTH-1:0] r_exp,       w_exp_d;
    logic [LAT_W-1:0]      r_lat_cnt,   w_lat_cnt_d;

    logic [DATA_WIDTH-1:0] w_seed_eff;
    logic [DATA_WIDTH-1:0] w_lfsr_state;
    logic                  w_lfsr_load;
    logic                  w_lfsr_adv;
    logic                  w_lat_last;
    logic                  w_last_pair;
    logic                  w_cmp_fire;
    logic                  w_mismatch;
    logic [ERR_CNT_W-1:0]  w_err_next;

    assign w_seed_eff  = (i_seed == '0) ? DATA_WIDTH'(1) : i_seed;
    assign w_lat_last  = (r_lat_cnt == LAT_W'(1));
    assign w_last_pair = (r_idx == IDX_W'(NUM_TXN - 1));
    // Abort wins over the compare that would otherwise happen this cycle.
    assign w_cmp_fire  = (r_state == StWait) && w_lat_last && !i_abort;
    assign w_mismatch  = w_cmp_fire && (io_bus.rdata != r_exp);
    assign w_err_next  = (w_mismatch && (r_err_cnt != '1)) ? r_err_cnt + ERR_CNT_W'(1)
                                                            : r_err_cnt;

    assign w_lfsr_load = (r_state == StIdle) && (w_state_d == StWrite);
    assign w_lfsr_adv  = (r_state == StWrite);

    mem_bist_lfsr #(
        .DATA_WIDTH (DATA_WIDTH),
        .LFSR_TAPS  (LFSR_TAPS)
    ) u_lfsr (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_load    (w_lfsr_load),
        .i_seed    (w_seed_eff),
        .i_advance (w_lfsr_adv),
        .o_state   (w_lfsr_state)
    );

    // State register.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StIdle: begin
                if (i_start && !i_abort) begin
                    w_state_d = StWrite;
                end
            end
            StWrite: w_state_d = i_abort ? StIdle : StRead;
            StRead:  w_state_d = i_abort ? StIdle : StWait;
            StWait: begin
                if (i_abort) begin
                    w_state_d = StIdle;
                end else if (w_lat_last) begin
                    w_state_d = w_last_pair ? StDone : StWrite;
                end
            end
            StDone:  w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase
    end

    // Output and datapath next values; strobes are computed from the next
    // state so that they line up with the state once registered.
    always_comb begin
        w_addr_d      = r_addr;
        w_wr_en_d     = 1'b0;
        w_rd_en_d     = 1'b0;
        w_wdata_d     = r_wdata;
        w_busy_d      = (w_state_d == StWrite) || (w_state_d == StRead) ||
                        (w_state_d == StWait);
        w_done_d      = 1'b0;
        w_pass_d      = r_pass;
        w_err_cnt_d   = r_err_cnt;
        w_fail_addr_d = r_fail_addr;
        w_fail_exp_d  = r_fail_exp;
        w_fail_act_d  = r_fail_act;
        w_idx_d       = r_idx;
        w_exp_d       = r_exp;
        w_lat_cnt_d   = r_lat_cnt;

        unique case (r_state)
            StIdle: begin
                if (w_state_d == StWrite) begin
                    w_addr_d      = i_base_addr;
                    w_wdata_d     = w_seed_eff;
                    w_wr_en_d     = 1'b1;
                    w_idx_d       = '0;
                    w_pass_d      = 1'b0;
                    w_err_cnt_d   = '0;
                    w_fail_addr_d = '0;
                    w_fail_exp_d  = '0;
                    w_fail_act_d  = '0;
                end
            end
            StWrite: begin
                w_exp_d   = w_lfsr_state;
                w_rd_en_d = (w_state_d == StRead);
            end
            StRead: begin
                w_lat_cnt_d = LAT_W'(RD_LATENCY);
            end
            StWait: begin
                w_lat_cnt_d = r_lat_cnt - LAT_W'(1);
                w_err_cnt_d = w_err_next;
                // A zero count before this compare marks the first mismatch.
                if (w_mismatch && (r_err_cnt == '0)) begin
                    w_fail_addr_d = r_addr;
                    w_fail_exp_d  = r_exp;
                    w_fail_act_d  = io_bus.rdata;
                end
                if (w_state_d == StWrite) begin
                    w_idx_d   = r_idx + IDX_W'(1);
                    w_addr_d  = r_addr + ADDR_WIDTH'(1);
                    w_wdata_d = w_lfsr_state;
                    w_wr_en_d = 1'b1;
                end
                if (w_state_d == StDone) begin
                    w_done_d = 1'b1;
                    w_pass_d = (w_err_next == '0);
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_addr      <= '0;
            r_wr_en     <= 1'b0;
            r_rd_en     <= 1'b0;
            r_wdata     <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_err_cnt   <= '0;
            r_fail_addr <= '0;
            r_fail_exp  <= '0;
            r_fail_act  <= '0;
            r_idx       <= '0;
            r_exp       <= '0;
            r_lat_cnt   <= '0;
        end else begin
            r_addr      <= w_addr_d;
            r_wr_en     <= w_wr_en_d;
            r_rd_en     <= w_rd_en_d;
            r_wdata     <= w_wdata_d;
            r_busy      <= w_busy_d;
            r_done      <= w_done_d;
            r_pass      <= w_pass_d;
            r_err_cnt   <= w_err_cnt_d;
            r_fail_addr <= w_fail_addr_d;
            r_fail_exp  <= w_fail_exp_d;
            r_fail_act  <= w_fail_act_d;
            r_idx       <= w_idx_d;
            r_exp       <= w_exp_d;
            r_lat_cnt   <= w_lat_cnt_d;
        end
    end

    assign io_bus.addr  = r_addr;
    assign io_bus.wr_en = r_wr_en;
    assign io_bus.rd_en = r_rd_en;
    assign io_bus.wdata = r_wdata;
    assign o_busy       = r_busy;
    assign o_done       = r_done;
    assign o_pass       = r_pass;
    assign o_err_cnt    = r_err_cnt;
    assign o_fail_addr  = r_fail_addr;
    assign o_fail_exp   = r_fail_exp;
    assign o_fail_act   = r_fail_act;

endmodule

// File: tb/tb_mem_bist_initiator.sv
// Bench for mem_bist_initiator: one instance with a 1-cycle memory, one with a
// 3-cycle memory. Writes and end-of-run results are checked against queues
// filled when each run is started.
module tb_mem_bist_initiator;

    localparam int AW      = 2;
    localparam int DW      = 8;
    localparam int NUM_TXN = 5;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    typedef struct {
        logic          pass;
        logic [7:0]    err;
        logic [AW-1:0] faddr;
        logic [DW-1:0] fexp;
        logic [DW-1:0] fact;
    } res_t;

    typedef struct {
        bit            lat3;
        logic [DW-1:0] seed;
        logic [AW-1:0] base;
        bit            stuck;
        int            lat;
        logic          pass;
        logic [7:0]    err;
        logic [AW-1:0] faddr;
        logic [DW-1:0] fexp;
        logic [DW-1:0] fact;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          start1, abort1, start3, abort3;
    logic [AW-1:0] base1, base3;
    logic [DW-1:0] seed1, seed3;
    logic          stuck1, stuck3;

    logic          busy1, done1, pass1, busy3, done3, pass3;
    logic [7:0]    err1, err3;
    logic [AW-1:0] faddr1, faddr3;
    logic [DW-1:0] fexp1, fact1, fexp3, fact3;

    int n_checks = 0;
    int n_errors = 0;

    wr_t  q_wr1[$];
    wr_t  q_wr3[$];
    res_t q_res1[$];
    res_t q_res3[$];

    mem_bist_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus1 ();
    mem_bist_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus3 ();

    mem_bist_initiator #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .NUM_TXN    (NUM_TXN),
        .RD_LATENCY (1),
        .LFSR_TAPS  (8'hB8)
    ) dut1 (
        .i_clk       (clk),
        .i_reset     (rst_n),
        .i_start     (start1),
        .i_abort     (abort1),
        .i_base_addr (base1),
        .i_seed      (seed1),
        .io_bus      (bus1),
        .o_busy      (busy1),
        .o_done      (done1),
        .o_pass      (pass1),
        .o_err_cnt   (err1),
        .o_fail_addr (faddr1),
        .o_fail_exp  (fexp1),
        .o_fail_act  (fact1)
    );

    mem_bist_initiator #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .NUM_TXN    (NUM_TXN),
        .RD_LATENCY (3),
        .LFSR_TAPS  (8'hB8)
    ) dut3 (
        .i_clk       (clk),
        .i_reset     (rst_n),
        .i_start     (start3),
        .i_abort     (abort3),
        .i_base_addr (base3),
        .i_seed      (seed3),
        .io_bus      (bus3),
        .o_busy      (busy3),
        .o_done      (done3),
        .o_pass      (pass3),
        .o_err_cnt   (err3),
        .o_fail_addr (faddr3),
        .o_fail_exp  (fexp3),
        .o_fail_act  (fact3)
    );

    // Memory models; rdata is zero except on the exact valid cycle, and
    // the stuck flag forces bit 7 of read data low.
    logic [DW-1:0] mem1 [4];
    logic [DW-1:0] mem3 [4];
    logic [DW-1:0] rd1_q;
    logic [DW-1:0] rd3_q [3];

    always @(posedge clk) begin
        if (bus1.wr_en === 1'b1) mem1[bus1.addr] <= bus1.wdata;
        if (bus1.rd_en === 1'b1) rd1_q <= stuck1 ? (mem1[bus1.addr] & 8'h7F) : mem1[bus1.addr];
        else                     rd1_q <= 8'h00;
    end
    assign bus1.rdata = rd1_q;

    always @(posedge clk) begin
        if (bus3.wr_en === 1'b1) mem3[bus3.addr] <= bus3.wdata;
        if (bus3.rd_en === 1'b1) rd3_q[0] <= stuck3 ? (mem3[bus3.addr] & 8'h7F) : mem3[bus3.addr];
        else                     rd3_q[0] <= 8'h00;
        rd3_q[1] <= rd3_q[0];
        rd3_q[2] <= rd3_q[1];
    end
    assign bus3.rdata = rd3_q[2];

    function automatic logic [DW-1:0] lfsr_step(input logic [DW-1:0] s);
        return s[0] ? ((s >> 1) ^ 8'hB8) : (s >> 1);
    endfunction

    function automatic logic get_done(input bit sel);
        return sel ? done3 : done1;
    endfunction

    function automatic logic get_pass(input bit sel);
        return sel ? pass3 : pass1;
    endfunction

    function automatic logic get_busy(input bit sel);
        return sel ? busy3 : busy1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: event seen where none was expected", name);
    endtask

    task automatic monitor(input bit sel);
        wr_t           e;
        res_t          r;
        string         tag;
        logic          wr, rd, dn, ps, by;
        logic [AW-1:0] a, fa;
        logic [DW-1:0] wd, fe, fc;
        logic [7:0]    ec;
        bit            empty;
        tag = sel ? "dut3" : "dut1";
        if (sel) begin
            wr = bus3.wr_en; rd = bus3.rd_en; a = bus3.addr; wd = bus3.wdata;
            dn = done3; ps = pass3; by = busy3; ec = err3; fa = faddr3; fe = fexp3; fc = fact3;
        end else begin
            wr = bus1.wr_en; rd = bus1.rd_en; a = bus1.addr; wd = bus1.wdata;
            dn = done1; ps = pass1; by = busy1; ec = err1; fa = faddr1; fe = fexp1; fc = fact1;
        end
        if (wr === 1'b1 && rd === 1'b1) fail_now({tag, "_strobes_both_high"});
        if (wr === 1'b1) begin
            empty = sel ? (q_wr3.size() == 0) : (q_wr1.size() == 0);
            if (empty) fail_now({tag, "_unexpected_write"});
            else begin
                if (sel) e = q_wr3.pop_front();
                else     e = q_wr1.pop_front();
                chk({tag, "_wr_addr"}, 32'(a), 32'(e.addr));
                chk({tag, "_wr_data"}, 32'(wd), 32'(e.data));
            end
        end
        if (dn === 1'b1) begin
            empty = sel ? (q_res3.size() == 0) : (q_res1.size() == 0);
            if (empty) fail_now({tag, "_unexpected_done"});
            else begin
                if (sel) r = q_res3.pop_front();
                else     r = q_res1.pop_front();
                chk({tag, "_pass"},      32'(ps), 32'(r.pass));
                chk({tag, "_err_cnt"},   32'(ec), 32'(r.err));
                chk({tag, "_fail_addr"}, 32'(fa), 32'(r.faddr));
                chk({tag, "_fail_exp"},  32'(fe), 32'(r.fexp));
                chk({tag, "_fail_act"},  32'(fc), 32'(r.fact));
                chk({tag, "_busy_at_done"}, 32'(by), 32'd0);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        monitor(1'b0);
        monitor(1'b1);
    endtask

    // Queue the expected writes (and result), pulse start for one edge.
    task automatic start_run(input bit sel, input logic [DW-1:0] seed, input logic [AW-1:0] base,
                             input bit push_res, input res_t r);
        logic [DW-1:0] s;
        wr_t           e;
        s = (seed == 8'h00) ? 8'h01 : seed;
        for (int i = 0; i < NUM_TXN; i++) begin
            e.addr = base + AW'(i);
            e.data = s;
            if (sel) q_wr3.push_back(e);
            else     q_wr1.push_back(e);
            s = lfsr_step(s);
        end
        if (push_res) begin
            if (sel) q_res3.push_back(r);
            else     q_res1.push_back(r);
        end
        if (sel) begin start3 = 1'b1; seed3 = seed; base3 = base; end
        else     begin start1 = 1'b1; seed1 = seed; base1 = base; end
        tick();
        start1 = 1'b0;
        start3 = 1'b0;
    endtask

    task automatic wait_done(input bit sel, input int start_n, input int exp_lat, input string tag);
        int n;
        n = start_n;
        while (get_done(sel) !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        chk({tag, "_done_latency"}, 32'(n), 32'(exp_lat));
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        res_t r;
        if (v.lat3) stuck3 = v.stuck;
        else        stuck1 = v.stuck;
        r.pass = v.pass; r.err = v.err; r.faddr = v.faddr; r.fexp = v.fexp; r.fact = v.fact;
        start_run(v.lat3, v.seed, v.base, 1'b1, r);
        wait_done(v.lat3, 1, v.lat, tag);
        tick();
        chk({tag, "_done_one_cycle"}, 32'(get_done(v.lat3)), 32'd0);
        chk({tag, "_pass_held"},      32'(get_pass(v.lat3)), 32'(v.pass));
        chk({tag, "_busy_after"},     32'(get_busy(v.lat3)), 32'd0);
    endtask

    vec_t vecs[5];

    initial begin
        res_t r;
        vec_t v;

        vecs[0] = '{1'b0, 8'h01, 2'd0, 1'b0, 16, 1'b1, 8'd0, 2'd0, 8'h00, 8'h00};
        vecs[1] = '{1'b0, 8'h01, 2'd0, 1'b1, 16, 1'b0, 8'd1, 2'd1, 8'hB8, 8'h38};
        vecs[2] = '{1'b0, 8'h00, 2'd3, 1'b0, 16, 1'b1, 8'd0, 2'd0, 8'h00, 8'h00};
        vecs[3] = '{1'b0, 8'h5A, 2'd2, 1'b1, 16, 1'b0, 8'd2, 2'd0, 8'hAE, 8'h2E};
        vecs[4] = '{1'b1, 8'h01, 2'd1, 1'b0, 26, 1'b1, 8'd0, 2'd0, 8'h00, 8'h00};

        rst_n = 1'b0;
        start1 = 1'b0; abort1 = 1'b0; base1 = '0; seed1 = '0; stuck1 = 1'b0;
        start3 = 1'b0; abort3 = 1'b0; base3 = '0; seed3 = '0; stuck3 = 1'b0;
        r = '{1'b0, 8'd0, 2'd0, 8'h00, 8'h00};

        tick();
        tick();
        chk("rst_busy1",  32'(busy1),       32'd0);
        chk("rst_done1",  32'(done1),       32'd0);
        chk("rst_pass1",  32'(pass1),       32'd0);
        chk("rst_err1",   32'(err1),        32'd0);
        chk("rst_wr_en1", 32'(bus1.wr_en),  32'd0);
        chk("rst_rd_en1", 32'(bus1.rd_en),  32'd0);
        chk("rst_busy3",  32'(busy3),       32'd0);
        chk("rst_done3",  32'(done3),       32'd0);
        chk("rst_pass3",  32'(pass3),       32'd0);
        chk("rst_err3",   32'(err3),        32'd0);
        chk("rst_wr_en3", 32'(bus3.wr_en),  32'd0);
        chk("rst_rd_en3", 32'(bus3.rd_en),  32'd0);
        rst_n = 1'b1;
        tick();

        for (int k = 0; k < 5; k++) begin
            run_vec(vecs[k], $sformatf("vec%0d", k));
        end

        // Abort in the second pair's wait cycle, then a clean rerun.
        stuck1 = 1'b0;
        start_run(1'b0, 8'h01, 2'd0, 1'b0, r);
        repeat (5) tick();
        chk("abort_pre_rd_en", 32'(bus1.rd_en), 32'd0);
        chk("abort_pre_busy",  32'(busy1),      32'd1);
        abort1 = 1'b1;
        tick();
        abort1 = 1'b0;
        chk("abort_busy",  32'(busy1),      32'd0);
        chk("abort_wr_en", 32'(bus1.wr_en), 32'd0);
        chk("abort_rd_en", 32'(bus1.rd_en), 32'd0);
        chk("abort_pass",  32'(pass1),      32'd0);
        chk("abort_done",  32'(done1),      32'd0);
        chk("abort_pending_writes", 32'(q_wr1.size()), 32'd3);
        q_wr1.delete();
        repeat (20) tick();
        chk("abort_still_idle", 32'(busy1), 32'd0);
        v = vecs[0];
        run_vec(v, "after_abort");

        // Start and abort together while idle: abort wins.
        start1 = 1'b1; abort1 = 1'b1; seed1 = 8'h33;
        tick();
        start1 = 1'b0; abort1 = 1'b0;
        chk("start_abort_busy", 32'(busy1), 32'd0);
        repeat (3) tick();

        // A second start while busy is ignored.
        r = '{1'b1, 8'd0, 2'd0, 8'h00, 8'h00};
        start_run(1'b0, 8'h01, 2'd0, 1'b1, r);
        repeat (2) tick();
        start1 = 1'b1; seed1 = 8'h77; base1 = 2'd2;
        tick();
        start1 = 1'b0;
        wait_done(1'b0, 4, 16, "restart_ignored");
        tick();

        // Reset in the third pair's write, after a mismatch has been logged.
        stuck1 = 1'b1;
        start_run(1'b0, 8'h01, 2'd0, 1'b0, r);
        repeat (6) tick();
        chk("pre_rst_wr_en", 32'(bus1.wr_en), 32'd1);
        chk("pre_rst_err",   32'(err1),       32'd1);
        chk("pre_rst_faddr", 32'(faddr1),     32'd1);
        rst_n = 1'b0;
        tick();
        chk("mid_rst_wr_en", 32'(bus1.wr_en), 32'd0);
        chk("mid_rst_rd_en", 32'(bus1.rd_en), 32'd0);
        chk("mid_rst_addr",  32'(bus1.addr),  32'd0);
        chk("mid_rst_wdata", 32'(bus1.wdata), 32'd0);
        chk("mid_rst_busy",  32'(busy1),      32'd0);
        chk("mid_rst_done",  32'(done1),      32'd0);
        chk("mid_rst_pass",  32'(pass1),      32'd0);
        chk("mid_rst_err",   32'(err1),       32'd0);
        chk("mid_rst_faddr", 32'(faddr1),     32'd0);
        chk("mid_rst_fexp",  32'(fexp1),      32'd0);
        chk("mid_rst_fact",  32'(fact1),      32'd0);
        rst_n = 1'b1;
        stuck1 = 1'b0;
        q_wr1.delete();
        repeat (3) tick();
        chk("post_rst_idle", 32'(busy1), 32'd0);

        chk("leftover_writes1",  32'(q_wr1.size()),  32'd0);
        chk("leftover_writes3",  32'(q_wr3.size()),  32'd0);
        chk("leftover_results1", 32'(q_res1.size()), 32'd0);
        chk("leftover_results3", 32'(q_res3.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
